// File: rtl/houghlines_accel_hls_dl_pkg.sv
// Shared types and helpers for the houghlines dataflow deadlock reporting logic.
// Report consumers size process ids with DL_PROC_ID_W.
package houghlines_accel_hls_dl_pkg;

  localparam int DL_PROC_NUM  = 4;
  localparam int DL_PROC_ID_W = $clog2(DL_PROC_NUM);
  localparam int DL_MAX_PROC  = 32;
  localparam int DL_MAX_ID_W  = 5;

  typedef enum logic [1:0] {
    DL_IDLE   = 2'd0,
    DL_ORIGIN = 2'd1,
    DL_TRACE  = 2'd2,
    DL_REPORT = 2'd3
  } dl_state_e;

  function automatic logic [DL_MAX_PROC-1:0] dl_onehot(input logic [DL_MAX_ID_W-1:0] idx);
    return {{(DL_MAX_PROC-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Lowest set bit wins; an all-zero vector yields index 0.
  function automatic logic [DL_MAX_ID_W-1:0] dl_prio_enc(input logic [DL_MAX_PROC-1:0] vec);
    logic [DL_MAX_ID_W-1:0] idx;
    idx = {DL_MAX_ID_W{1'b0}};
    for (int i = DL_MAX_PROC - 1; i >= 0; i--) begin
      idx = vec[i] ? DL_MAX_ID_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/houghlines_accel_hls_dl_prio_enc.sv
// Combinational lowest-index picker over the detect-unit flags.
module houghlines_accel_hls_dl_prio_enc
  import houghlines_accel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM = DL_PROC_NUM,
  parameter int ID_W     = $clog2(PROC_NUM)
) (
  input  logic [PROC_NUM-1:0] vec,
  output logic [ID_W-1:0]     idx,
  output logic                hit
);

  logic [DL_MAX_PROC-1:0] vec_ext_s;

  assign vec_ext_s = DL_MAX_PROC'(vec);
  assign idx       = ID_W'(dl_prio_enc(vec_ext_s));
  assign hit       = |vec;

endmodule

// File: rtl/houghlines_accel_hls_deadlock_report_ctrl.sv
// Deadlock trace sequencer: debounces detect flags, broadcasts the trace, waits for the
// token to return to the origin, and holds a sticky report until acknowledged.
module houghlines_accel_hls_deadlock_report_ctrl
  import houghlines_accel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TRACE_TIMEOUT  = 1024,
  parameter int STAMP_W        = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [PROC_NUM-1:0]         dl_detect_vec,
  input  logic                        report_ack,
  output logic                        dl_detect_bcast,
  output logic [PROC_NUM-1:0]         origin_vec,
  output logic [PROC_NUM-1:0]         token_clear_vec,
  output logic                        dl_valid,
  output logic [$clog2(PROC_NUM)-1:0] dl_origin_id,
  output logic [PROC_NUM-1:0]         dl_proc_mask,
  output logic [STAMP_W-1:0]          dl_stamp,
  output logic                        timeout_pulse
);

  localparam int ID_W  = $clog2(PROC_NUM);
  localparam int CNF_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int TMR_W = $clog2(TRACE_TIMEOUT);
  localparam logic [CNF_W-1:0] CNF_LAST = CNF_W'(CONFIRM_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TRACE_TIMEOUT - 1);

  dl_state_e           state_r, state_nxt_s;
  logic [CNF_W-1:0]    cnf_cnt_r, cnf_cnt_nxt_s;
  logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
  logic [ID_W-1:0]     id_r, id_nxt_s;
  logic [PROC_NUM-1:0] mask_r, mask_nxt_s;
  logic [STAMP_W-1:0]  stamp_r;

  logic                bcast_r, bcast_nxt_s;
  logic [PROC_NUM-1:0] origin_r, origin_nxt_s;
  logic [PROC_NUM-1:0] tclr_r, tclr_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic [ID_W-1:0]     oid_r, oid_nxt_s;
  logic [PROC_NUM-1:0] pmask_r, pmask_nxt_s;
  logic [STAMP_W-1:0]  dstamp_r, dstamp_nxt_s;
  logic                tmo_r, tmo_nxt_s;

  logic [ID_W-1:0]     enc_idx_s;
  logic                enc_hit_s;
  logic [PROC_NUM-1:0] enc_oh_s;
  logic [PROC_NUM-1:0] id_oh_s;
  logic                confirm_hit_s;
  logic                ret_hit_s;
  logic                tmo_hit_s;

  houghlines_accel_hls_dl_prio_enc #(
    .PROC_NUM (PROC_NUM),
    .ID_W     (ID_W)
  ) u_prio_enc (
    .vec (dl_detect_vec),
    .idx (enc_idx_s),
    .hit (enc_hit_s)
  );

  assign enc_oh_s      = PROC_NUM'(dl_onehot(DL_MAX_ID_W'(enc_idx_s)));
  assign id_oh_s       = PROC_NUM'(dl_onehot(DL_MAX_ID_W'(id_r)));
  assign confirm_hit_s = enc_hit_s && (cnf_cnt_r == CNF_LAST);
  assign ret_hit_s     = dl_detect_vec[id_r];
  assign tmo_hit_s     = (tmr_r == TMR_LAST);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= DL_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode; a return on the timeout cycle still counts as a return
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = DL_IDLE;
    end else begin
      case (state_r)
        DL_IDLE:   state_nxt_s = confirm_hit_s ? DL_ORIGIN : DL_IDLE;
        DL_ORIGIN: state_nxt_s = DL_TRACE;
        DL_TRACE: begin
          if (ret_hit_s) begin
            state_nxt_s = DL_REPORT;
          end else if (tmo_hit_s) begin
            state_nxt_s = DL_IDLE;
          end else begin
            state_nxt_s = DL_TRACE;
          end
        end
        DL_REPORT: state_nxt_s = report_ack ? DL_IDLE : DL_REPORT;
        default:   state_nxt_s = DL_IDLE;
      endcase
    end
  end

  // Next values for counters and registered outputs
  always_comb begin
    cnf_cnt_nxt_s = cnf_cnt_r;
    tmr_nxt_s     = tmr_r;
    id_nxt_s      = id_r;
    mask_nxt_s    = mask_r;
    origin_nxt_s  = {PROC_NUM{1'b0}};
    tclr_nxt_s    = {PROC_NUM{1'b0}};
    tmo_nxt_s     = 1'b0;
    valid_nxt_s   = valid_r;
    oid_nxt_s     = oid_r;
    pmask_nxt_s   = pmask_r;
    dstamp_nxt_s  = dstamp_r;
    bcast_nxt_s   = (state_nxt_s != DL_IDLE) ? 1'b1 : 1'b0;
    if (!enable) begin
      cnf_cnt_nxt_s = {CNF_W{1'b0}};
      tmr_nxt_s     = {TMR_W{1'b0}};
      id_nxt_s      = {ID_W{1'b0}};
      mask_nxt_s    = {PROC_NUM{1'b0}};
      valid_nxt_s   = 1'b0;
      oid_nxt_s     = {ID_W{1'b0}};
      pmask_nxt_s   = {PROC_NUM{1'b0}};
      dstamp_nxt_s  = {STAMP_W{1'b0}};
    end else begin
      case (state_r)
        DL_IDLE: begin
          if (confirm_hit_s) begin
            cnf_cnt_nxt_s = {CNF_W{1'b0}};
            id_nxt_s      = enc_idx_s;
            origin_nxt_s  = enc_oh_s;
          end else if (enc_hit_s) begin
            cnf_cnt_nxt_s = cnf_cnt_r + CNF_W'(1'b1);
          end else begin
            cnf_cnt_nxt_s = {CNF_W{1'b0}};
          end
        end
        DL_ORIGIN: begin
          mask_nxt_s = id_oh_s;
          tmr_nxt_s  = {TMR_W{1'b0}};
        end
        DL_TRACE: begin
          if (ret_hit_s) begin
            tclr_nxt_s   = id_oh_s;
            valid_nxt_s  = 1'b1;
            oid_nxt_s    = id_r;
            pmask_nxt_s  = mask_r | dl_detect_vec;
            dstamp_nxt_s = stamp_r;
          end else if (tmo_hit_s) begin
            tmo_nxt_s     = 1'b1;
            mask_nxt_s    = {PROC_NUM{1'b0}};
            tmr_nxt_s     = {TMR_W{1'b0}};
            cnf_cnt_nxt_s = {CNF_W{1'b0}};
          end else begin
            mask_nxt_s = mask_r | dl_detect_vec;
            tmr_nxt_s  = tmr_r + TMR_W'(1'b1);
          end
        end
        DL_REPORT: begin
          if (report_ack) begin
            valid_nxt_s   = 1'b0;
            cnf_cnt_nxt_s = {CNF_W{1'b0}};
          end else begin
            valid_nxt_s = valid_r;
          end
        end
        default: begin
          cnf_cnt_nxt_s = {CNF_W{1'b0}};
          valid_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // Counter, trace and report registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnf_cnt_r <= {CNF_W{1'b0}};
      tmr_r     <= {TMR_W{1'b0}};
      id_r      <= {ID_W{1'b0}};
      mask_r    <= {PROC_NUM{1'b0}};
      bcast_r   <= 1'b0;
      origin_r  <= {PROC_NUM{1'b0}};
      tclr_r    <= {PROC_NUM{1'b0}};
      valid_r   <= 1'b0;
      oid_r     <= {ID_W{1'b0}};
      pmask_r   <= {PROC_NUM{1'b0}};
      dstamp_r  <= {STAMP_W{1'b0}};
      tmo_r     <= 1'b0;
    end else begin
      cnf_cnt_r <= cnf_cnt_nxt_s;
      tmr_r     <= tmr_nxt_s;
      id_r      <= id_nxt_s;
      mask_r    <= mask_nxt_s;
      bcast_r   <= bcast_nxt_s;
      origin_r  <= origin_nxt_s;
      tclr_r    <= tclr_nxt_s;
      valid_r   <= valid_nxt_s;
      oid_r     <= oid_nxt_s;
      pmask_r   <= pmask_nxt_s;
      dstamp_r  <= dstamp_nxt_s;
      tmo_r     <= tmo_nxt_s;
    end
  end

  // Saturating free-running cycle stamp, independent of enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stamp_r <= {STAMP_W{1'b0}};
    end else if (stamp_r != {STAMP_W{1'b1}}) begin
      stamp_r <= stamp_r + STAMP_W'(1'b1);
    end else begin
      stamp_r <= stamp_r;
    end
  end

  assign dl_detect_bcast = bcast_r;
  assign origin_vec      = origin_r;
  assign token_clear_vec = tclr_r;
  assign dl_valid        = valid_r;
  assign dl_origin_id    = oid_r;
  assign dl_proc_mask    = pmask_r;
  assign dl_stamp        = dstamp_r;
  assign timeout_pulse   = tmo_r;

endmodule

// File: tb/tb_houghlines_accel_hls_deadlock_report_ctrl.sv
// Directed scenarios plus random traffic against a transaction-level model of the
// deadlock report sequencer; every output is compared on each falling edge.
module tb_houghlines_accel_hls_deadlock_report_ctrl;

  localparam int PN        = 4;
  localparam int CONFIRM   = 4;
  localparam int TIMEOUT   = 16;
  localparam int SW        = 10;
  localparam int STAMP_MAX = (1 << SW) - 1;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [PN-1:0] dl_detect_vec;
  logic          report_ack;
  logic          dl_detect_bcast;
  logic [PN-1:0] origin_vec;
  logic [PN-1:0] token_clear_vec;
  logic          dl_valid;
  logic [1:0]    dl_origin_id;
  logic [PN-1:0] dl_proc_mask;
  logic [SW-1:0] dl_stamp;
  logic          timeout_pulse;

  int n_checks;
  int n_fail;

  // reference model: a few plain variables describing where the trace stands
  int       m_streak;
  bit       m_origin_cyc;
  bit       m_tracing;
  bit       m_reporting;
  int       m_id;
  int       m_age;
  bit [3:0] m_seen;
  int       m_stamp;
  int       last_stamp;

  bit       e_bcast;
  bit [3:0] e_origin;
  bit [3:0] e_tclr;
  bit       e_valid;
  int       e_oid;
  bit [3:0] e_pmask;
  int       e_dstamp;
  bit       e_tmo;

  houghlines_accel_hls_deadlock_report_ctrl #(
    .PROC_NUM       (PN),
    .CONFIRM_CYCLES (CONFIRM),
    .TRACE_TIMEOUT  (TIMEOUT),
    .STAMP_W        (SW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .dl_detect_vec   (dl_detect_vec),
    .report_ack      (report_ack),
    .dl_detect_bcast (dl_detect_bcast),
    .origin_vec      (origin_vec),
    .token_clear_vec (token_clear_vec),
    .dl_valid        (dl_valid),
    .dl_origin_id    (dl_origin_id),
    .dl_proc_mask    (dl_proc_mask),
    .dl_stamp        (dl_stamp),
    .timeout_pulse   (timeout_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_streak = 0; m_origin_cyc = 0; m_tracing = 0; m_reporting = 0;
    m_id = 0; m_age = 0; m_seen = 4'b0000; m_stamp = 0; last_stamp = 0;
    e_bcast = 0; e_origin = 4'b0000; e_tclr = 4'b0000; e_valid = 0;
    e_oid = 0; e_pmask = 4'b0000; e_dstamp = 0; e_tmo = 0;
  endtask

  task automatic model_edge(input bit [3:0] v, input bit a, input bit en);
    int s;
    s = m_stamp;
    m_stamp = (s < STAMP_MAX) ? s + 1 : STAMP_MAX;
    e_origin = 4'b0000; e_tclr = 4'b0000; e_tmo = 0;
    if (!en) begin
      m_streak = 0; m_origin_cyc = 0; m_tracing = 0; m_reporting = 0; m_seen = 4'b0000;
      e_bcast = 0; e_valid = 0; e_oid = 0; e_pmask = 4'b0000; e_dstamp = 0;
    end else if (m_origin_cyc) begin
      m_origin_cyc = 0; m_tracing = 1; m_age = 0;
      m_seen = 4'b0001 << m_id;
    end else if (m_tracing) begin
      if (v[m_id]) begin
        e_tclr = 4'b0001 << m_id; e_valid = 1; e_oid = m_id;
        e_pmask = m_seen | v; e_dstamp = s;
        m_tracing = 0; m_reporting = 1;
      end else if (m_age == TIMEOUT - 1) begin
        e_tmo = 1; e_bcast = 0; m_tracing = 0; m_seen = 4'b0000; m_streak = 0;
      end else begin
        m_seen = m_seen | v; m_age++;
      end
    end else if (m_reporting) begin
      if (a) begin
        e_valid = 0; e_bcast = 0; m_reporting = 0; m_streak = 0;
      end
    end else begin
      m_streak = (v != 4'b0000) ? m_streak + 1 : 0;
      if (m_streak == CONFIRM) begin
        m_id = 0;
        for (int i = PN - 1; i >= 0; i--) if (v[i]) m_id = i;
        e_origin = 4'b0001 << m_id; e_bcast = 1; m_origin_cyc = 1; m_streak = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("bcast", dl_detect_bcast, e_bcast);
    check_eq("origin_vec", origin_vec, e_origin);
    check_eq("token_clear_vec", token_clear_vec, e_tclr);
    check_eq("dl_valid", dl_valid, e_valid);
    check_eq("dl_origin_id", dl_origin_id, e_oid);
    check_eq("dl_proc_mask", dl_proc_mask, e_pmask);
    check_eq("dl_stamp", dl_stamp, e_dstamp);
    check_eq("timeout_pulse", timeout_pulse, e_tmo);
    if (e_tclr != 4'b0000) begin
      check_eq("stamp_monotonic", (int'(dl_stamp) >= last_stamp), 1);
      last_stamp = int'(dl_stamp);
    end
  endtask

  // inputs change on the falling edge; outputs are checked on the next falling edge
  task automatic drive(input logic [3:0] v, input logic a, input logic en);
    dl_detect_vec = v; report_ack = a; enable = en;
    @(posedge clock);
    model_edge(v, a, en);
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; enable = 1'b0; dl_detect_vec = 4'b0000; report_ack = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // single flag held CONFIRM cycles
    repeat (3) drive(4'b0100, 1'b0, 1'b1);
    check_eq("t1_origin_early", origin_vec, 4'b0000);
    drive(4'b0100, 1'b0, 1'b1);
    check_eq("t1_origin", origin_vec, 4'b0100);
    check_eq("t1_bcast", dl_detect_bcast, 1'b1);
    drive(4'b0100, 1'b0, 1'b1);
    check_eq("t1_origin_one_cycle", origin_vec, 4'b0000);
    drive(4'b0100, 1'b0, 1'b1);
    check_eq("t1_tclr", token_clear_vec, 4'b0100);
    drive(4'b0000, 1'b1, 1'b1);

    // broken streak never confirms
    repeat (3) drive(4'b0010, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    repeat (3) drive(4'b0010, 1'b0, 1'b1);
    check_eq("t2_no_origin", origin_vec, 4'b0000);
    drive(4'b0000, 1'b0, 1'b1);
    check_eq("t2_idle_bcast", dl_detect_bcast, 1'b0);

    // simultaneous flags, lowest wins; another unit joins before the return
    repeat (4) drive(4'b1010, 1'b0, 1'b1);
    check_eq("t3_origin", origin_vec, 4'b0010);
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b1000, 1'b0, 1'b1);
    check_eq("t3_no_tclr", token_clear_vec, 4'b0000);
    drive(4'b0010, 1'b0, 1'b1);
    check_eq("t3_tclr", token_clear_vec, 4'b0010);
    check_eq("t3_valid", dl_valid, 1'b1);
    check_eq("t3_mask", dl_proc_mask, 4'b1010);
    check_eq("t3_id", dl_origin_id, 2'd1);
    drive(4'b0000, 1'b0, 1'b1);
    check_eq("t3_tclr_pulse", token_clear_vec, 4'b0000);
    check_eq("t3_valid_sticky", dl_valid, 1'b1);
    drive(4'b0000, 1'b1, 1'b1);
    check_eq("t5_ack_valid", dl_valid, 1'b0);
    check_eq("t5_ack_bcast", dl_detect_bcast, 1'b0);

    // origin never returns
    repeat (4) drive(4'b0001, 1'b0, 1'b1);
    check_eq("t4_origin", origin_vec, 4'b0001);
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < TIMEOUT; i++) begin
      drive((i % 2 == 1) ? 4'b0100 : 4'b0000, 1'b0, 1'b1);
      check_eq("t4_timeout", timeout_pulse, (i == TIMEOUT - 1) ? 1'b1 : 1'b0);
    end
    check_eq("t4_bcast", dl_detect_bcast, 1'b0);
    check_eq("t4_valid", dl_valid, 1'b0);
    drive(4'b0000, 1'b0, 1'b1);
    check_eq("t4_pulse_once", timeout_pulse, 1'b0);

    // ack during TRACE is ignored
    repeat (4) drive(4'b0100, 1'b1, 1'b1);
    drive(4'b0000, 1'b1, 1'b1);
    drive(4'b0001, 1'b1, 1'b1);
    drive(4'b0100, 1'b1, 1'b1);
    check_eq("t5_trace_ack_valid", dl_valid, 1'b1);
    check_eq("t5_trace_ack_mask", dl_proc_mask, 4'b0101);
    drive(4'b0000, 1'b0, 1'b1);

    // enable drop in REPORT clears everything
    drive(4'b0000, 1'b0, 1'b0);
    check_eq("t6_en_valid", dl_valid, 1'b0);
    check_eq("t6_en_bcast", dl_detect_bcast, 1'b0);
    check_eq("t6_en_mask", dl_proc_mask, 4'b0000);
    drive(4'b0000, 1'b0, 1'b1);

    // asynchronous reset while tracing
    repeat (4) drive(4'b1000, 1'b0, 1'b1);
    repeat (3) drive(4'b0000, 1'b0, 1'b1);
    check_eq("t6_in_trace", dl_detect_bcast, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("t6_rst_bcast", dl_detect_bcast, 1'b0);
    compare_all();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b1;

    // random traffic, long enough for the stamp to saturate
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] v;
      logic       a;
      logic       en;
      v  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      en = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      drive(v, a, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
